pulp_serial_edge_tx: RTL and testbench
======================================

Name: pulp_serial_edge_tx

Overview:
Transmit-side counterpart of the synchronizer/edge-detector front end. It turns single-cycle pulse requests from local logic into a clean serial waveform. Each request becomes one high phase and one low phase on serial_o, each held a guaranteed minimum number of cycles, so a far-side multi-stage synchronizer with edge detection sees exactly one rising edge and one falling edge per request. Requests arriving while a pulse is in flight are queued in a saturating pending counter.

Parameters:
HOLD_CYCLES, 3, cycles each phase (high, low) is held; must be >= 1; set >= far-side sync STAGES+1
CNT_W, 4, width of the pending-request counter; max queued = 2^CNT_W-1

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
en_i  input  1  synchronous enable; low freezes FSM and timer, requests still counted
pulse_i  input  1  one-cycle request for one serial pulse
clr_i  input  1  flush queued requests
serial_o  output  1  registered serial line
busy_o  output  1  FSM not IDLE or pending != 0
pending_o  output  CNT_W  queued request count
ovf_o  output  1  registered one-cycle flag: a request was dropped

Behaviour:
- Reset values: serial_o=0, busy_o=0, pending_o=0, ovf_o=0, state IDLE, timer 0. Reset is asynchronous, so it may assert in any state.
- States: IDLE, HIGH, LOW. serial_o is a register and equals (state==HIGH).
- Timer: width $clog2(HOLD_CYCLES+1). Loaded with HOLD_CYCLES-1 on entry to HIGH or LOW. Decrements while en_i=1.
- IDLE -> HIGH when en_i=1 and (pending!=0 or pulse_i=1).
  - If pending==0 and pulse_i=1, the request bypasses the counter and pending stays 0.
  - Otherwise pending decrements on entry to HIGH.
- HIGH -> LOW when en_i=1 and timer==0.
- LOW -> IDLE when en_i=1 and timer==0.
- No direct LOW->HIGH transition. Minimum spacing between rising edges is 2*HOLD_CYCLES+1 cycles.
- Latency: pulse_i at cycle t from IDLE/empty gives serial_o=1 for cycles t+1..t+HOLD, serial_o=0 for t+HOLD+1..t+2*HOLD, and IDLE at t+2*HOLD+1.
- Pending counter, per cycle (clr_i has highest priority):
  - clr_i=1: counter goes to 0 next cycle. A same-cycle pulse_i is discarded and does not set ovf_o. A pulse in flight completes normally.
  - Simultaneous increment (accepted pulse_i) and decrement (entry to HIGH): count unchanged.
  - pulse_i with count == 2^CNT_W-1 and no same-cycle decrement: request dropped, count stays, ovf_o=1 the next cycle.
  - pulse_i is accepted in every state regardless of en_i.
- en_i=0 stretches the current phase by the number of disabled cycles. It does not change serial_o. Implemented as a plain synchronous enable (no gated clock).
- busy_o is combinational: (state!=IDLE) | (pending!=0).
- Reset mid-pulse forces serial_o low asynchronously. Queued requests are lost.

Decomposition:
- Package pulp_serial_edge_tx_pkg: state enum typedef (IDLE/HIGH/LOW, 2-bit) and a function for the timer width.
- Sub-module pulp_sat_updown_cnt (parameter W): saturating up/down counter with clear, inc, dec inputs and a sat_o output used to generate ovf_o.

Test Plan:
1. HOLD_CYCLES=3, single pulse_i at cycle 10 -> serial_o=1 cycles 11-13, 0 cycles 14-16; busy_o=0 from cycle 17; ovf_o never set.
2. pulse_i at cycles 10,11,12 -> pending_o reaches 2; rising edges at cycles 11, 18, 25; busy_o deasserts at 31; a reference sync-plus-edge-detect model (STAGES=2) counts exactly 3 r_edge and 3 f_edge.
3. CNT_W=2, pulse_i every cycle 10-14 -> cycle 10 bypasses, 11-13 queue (pending_o=3), cycle 14 dropped with ovf_o=1 at cycle 15; total 4 pulses emitted.
4. pulse_i at 10, en_i=0 cycles 12-16 -> serial_o high cycles 11-18 (3+5), low 19-21.
5. pulse_i at 10,11,12, clr_i at 13 -> pending_o=0 at 14; only the first pulse is emitted (high 11-13, low 14-16); simultaneous clr_i+pulse_i at 20 -> no pulse, ovf_o stays 0.
6. rstn_i asserted at cycle 12 during HIGH with pending=2 -> serial_o=0, pending_o=0, busy_o=0 immediately; after release a new pulse_i behaves as in test 1.

Source files
------------

// File: rtl/pulp_serial_edge_tx_pkg.sv
// Shared types for the serial edge transmitter: FSM state encoding and timer sizing.
package pulp_serial_edge_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Timer must hold HOLD_CYCLES-1; never let it collapse to zero width.
  function automatic int unsigned timer_w(input int unsigned hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/pulp_sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear; sat_o flags an increment lost at the top.
module pulp_sat_updown_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over everything; a paired inc+dec leaves the count alone.
  always_comb begin
    cnt_d = cnt_q;
    sat_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MAX) sat_o = 1'b1;
      else              cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulp_serial_edge_tx.sv
// Turns one-cycle pulse requests into held high/low phases on a registered serial line,
// queueing requests that arrive while a pulse is in flight.
module pulp_serial_edge_tx
  import pulp_serial_edge_tx_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             pulse_i,
  input  logic             clr_i,
  output logic             serial_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             ovf_o
);

  localparam int unsigned     TW    = timer_w(HOLD_CYCLES);
  localparam logic [TW-1:0]   TLOAD = TW'(HOLD_CYCLES - 1);

  state_e          state_q;
  logic [TW-1:0]   tmr_q;
  logic            serial_q, ovf_q;
  logic [CNT_W-1:0] pend;
  logic            sat, has_pend, start, bypass, inc, dec;

  assign has_pend = |pend;
  // A flush in the same cycle discards the incoming request, so it cannot launch a pulse either.
  assign start    = en_i && !clr_i && (state_q == ST_IDLE) && (has_pend || pulse_i);
  assign bypass   = start && !has_pend;
  assign inc      = pulse_i && !bypass;
  assign dec      = start && has_pend;

  pulp_sat_updown_cnt #(.W(CNT_W)) u_pend (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (clr_i),
    .inc_i  (inc),
    .dec_i  (dec),
    .cnt_o  (pend),
    .sat_o  (sat)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      serial_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= sat;
      if (en_i) begin
        case (state_q)
          ST_IDLE: if (start) begin
            state_q  <= ST_HIGH;
            tmr_q    <= TLOAD;
            serial_q <= 1'b1;
          end
          ST_HIGH: if (tmr_q == '0) begin
            state_q  <= ST_LOW;
            tmr_q    <= TLOAD;
            serial_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
          ST_LOW: if (tmr_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
          default: begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            serial_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign serial_o  = serial_q;
  assign busy_o    = (state_q != ST_IDLE) || has_pend;
  assign pending_o = pend;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pulp_serial_edge_tx.sv
// Directed bench: two instances (CNT_W=4 and CNT_W=2) share stimulus; hand-derived waveforms.
module tb_pulp_serial_edge_tx;

  logic clk_i = 1'b0, rstn_i = 1'b0, en_i = 1'b1, pulse_i = 1'b0, clr_i = 1'b0;
  logic ser1, busy1, ovf1, ser2, busy2, ovf2;
  logic [3:0] pend1;
  logic [1:0] pend2;
  int errs = 0, checks = 0;

  always #5 clk_i = ~clk_i;

  pulp_serial_edge_tx #(.HOLD_CYCLES(3), .CNT_W(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .pulse_i(pulse_i), .clr_i(clr_i),
    .serial_o(ser1), .busy_o(busy1), .pending_o(pend1), .ovf_o(ovf1)
  );

  pulp_serial_edge_tx #(.HOLD_CYCLES(3), .CNT_W(2)) dut2 (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .pulse_i(pulse_i), .clr_i(clr_i),
    .serial_o(ser2), .busy_o(busy2), .pending_o(pend2), .ovf_o(ovf2)
  );

  // Far-side receiver model: 2-stage sync plus edge detect on dut's line.
  logic [1:0] sync_q = 2'b00;
  logic       prev_q = 1'b0, edge_clr = 1'b0;
  int         redge = 0, fedge = 0;
  always @(posedge clk_i) begin
    sync_q <= {sync_q[0], ser1};
    prev_q <= sync_q[1];
    if (edge_clr) begin
      redge <= 0;
      fedge <= 0;
    end else begin
      if (sync_q[1] && !prev_q) redge <= redge + 1;
      if (!sync_q[1] && prev_q) fedge <= fedge + 1;
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; pulse_i = 1'b0; clr_i = 1'b0; en_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ser", ser1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_pend", pend1, 0);
    chk("rst_ovf", ovf1, 0);
    rstn_i = 1'b1;
  endtask

  // One 51-cycle scenario; cycle 0 begins right after reset release.
  task automatic run(input int id);
    int   npulse, r2;
    logic p2, e;
    npulse = (id == 2) ? 3 : (id == 3) ? 5 : 1;
    r2 = 0;
    p2 = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      if (id == 1 || id == 4)      pulse_i = (c == 10);
      else if (id == 3)            pulse_i = (c >= 10 && c <= 14);
      else                         pulse_i = (c >= 10 && c <= 12) || (id == 5 && c == 20);
      en_i     = !(id == 4 && c >= 12 && c <= 16);
      clr_i    = (id == 5) && (c == 13 || c == 20);
      edge_clr = (c == 0);
      e = 1'b0;
      if (id == 4) e = (c >= 11 && c <= 18);
      else for (int k = 0; k < npulse; k++) if (c >= 11 + 7*k && c <= 13 + 7*k) e = 1'b1;
      chk($sformatf("t%0d_ser_c%0d", id, c), ser1, e);
      chk($sformatf("t%0d_ovf_c%0d", id, c), ovf1, 0);
      if (id == 1 && (c == 16 || c == 17)) chk($sformatf("t1_busy_c%0d", c), busy1, c == 16);
      if (id == 2) begin
        if (c == 13) chk("t2_pend_c13", pend1, 2);
        if (c == 30 || c == 31) chk($sformatf("t2_busy_c%0d", c), busy1, c == 30);
      end
      if (id == 3) begin
        chk($sformatf("t3_ovf2_c%0d", c), ovf2, c == 15);
        if (c == 14 || c == 15) chk($sformatf("t3_pend2_c%0d", c), pend2, 3);
        if (ser2 && !p2) r2++;
        p2 = ser2;
      end
      if (id == 5) begin
        if (c == 13) chk("t5_pend_c13", pend1, 2);
        if (c == 14) chk("t5_pend_c14", pend1, 0);
        if (c == 21) chk("t5_busy_c21", busy1, 0);
      end
      tick();
    end
    pulse_i = 1'b0; clr_i = 1'b0; en_i = 1'b1;
    chk($sformatf("t%0d_redges", id), redge, npulse);
    chk($sformatf("t%0d_fedges", id), fedge, npulse);
    if (id == 3) chk("t3_pulses2", r2, 4);
  endtask

  initial begin
    for (int t = 1; t <= 5; t++) begin
      do_reset();
      run(t);
    end
    // Asynchronous reset while HIGH with two requests queued.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      pulse_i = (c >= 9 && c <= 11);
      if (c < 12) tick();
    end
    chk("t6_pre_ser", ser1, 1);
    chk("t6_pre_pend", pend1, 2);
    #2 rstn_i = 1'b0;
    #1;
    chk("t6_async_ser", ser1, 0);
    chk("t6_async_pend", pend1, 0);
    chk("t6_async_busy", busy1, 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    run(1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
